// File: rtl/filt_pkg.sv
// filt_pkg: shared constants and the event record used by the filter scheduler.
// The event record carries a channel index wide enough for up to 256 channels;
// the scheduler keeps only the low bits it needs.
package filt_pkg;

    localparam int THR_DEFAULT = 3;
    localparam int FIFO_DEPTH  = 4;
    localparam int FIFO_AW     = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW     = $clog2(FIFO_DEPTH + 1);
    localparam int EVT_CH_W    = 8;

    typedef struct packed {
        logic [EVT_CH_W-1:0] ch;
        logic                val;
    } evt_t;

endpackage

// File: rtl/filt_step.sv
// filt_step: one debounce step for a single channel. The scheduler feeds it the
// state of whichever channel the scan pointer selects, so a single instance
// serves every channel.
module filt_step #(
    parameter int CNT_W = 3
) (
    input  logic             i_din,
    input  logic             i_y,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_thrQ,
    input  logic             i_slotFree,
    output logic             o_nextY,
    output logic [CNT_W-1:0] o_nextCnt,
    output logic             o_push
);

    logic [CNT_W:0] w_inc;

    assign w_inc = {1'b0, i_cnt} + {{CNT_W{1'b0}}, 1'b1};

    // Agreeing sample clears the run; a disagreeing run either grows or, once it
    // reaches the threshold, flips the level provided the event can be queued.
    always_comb begin
        o_nextY   = i_y;
        o_nextCnt = i_cnt;
        o_push    = 1'b0;
        if (i_din == i_y) begin
            o_nextCnt = '0;
        end else if (w_inc < {1'b0, i_thrQ}) begin
            o_nextCnt = w_inc[CNT_W-1:0];
        end else if (i_slotFree) begin
            o_nextY   = ~i_y;
            o_nextCnt = '0;
            o_push    = 1'b1;
        end
    end

endmodule

// File: rtl/filt_sched.sv
// filt_sched: time-multiplexed debounce filter. A scan pointer visits one channel
// per enabled cycle; a channel's output flips after thr consecutive opposite
// samples and each flip is reported as an event {ch, val}.
// Optional feature: define FILT_SCHED_EVT_FIFO_EN to hold events in a 4-entry
// FIFO; otherwise a single event register is used.
module filt_sched
    import filt_pkg::*;
#(
    parameter  int NCH   = 8,
    parameter  int CNT_W = 3,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] thr,
    input  logic [NCH-1:0]   din,
    output logic [NCH-1:0]   y,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch,
    output logic             evt_val
);

    localparam logic [CH_W-1:0] LAST_PTR = CH_W'(NCH - 1);

    logic [CH_W-1:0]  r_ptr;
    logic [NCH-1:0]   r_y;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [CNT_W-1:0] r_thrQ;

    logic             w_ptrValid;
    logic             w_visit;
    logic             w_wrap;
    logic             w_nextY;
    logic [CNT_W-1:0] w_nextCnt;
    logic             w_stepPush;
    logic             w_push;
    logic             w_pop;
    logic             w_slotFree;
    logic             w_headValid;
    evt_t             w_head;
    evt_t             w_newEvt;
    logic             w_unusedChBits;

    generate
        if ((1 << CH_W) != NCH) begin : g_ptrCheck
            assign w_ptrValid = (r_ptr <= LAST_PTR);
        end else begin : g_ptrPow2
            assign w_ptrValid = 1'b1;
        end
    endgenerate

    assign w_visit  = en && w_ptrValid;
    assign w_wrap   = w_visit && (r_ptr == LAST_PTR);
    assign w_push   = w_visit && w_stepPush;
    assign w_pop    = w_headValid && evt_ready;
    assign w_newEvt = '{ch: EVT_CH_W'(r_ptr), val: w_nextY};

    filt_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .i_din      (din[r_ptr]),
        .i_y        (r_y[r_ptr]),
        .i_cnt      (r_cnt[r_ptr]),
        .i_thrQ     (r_thrQ),
        .i_slotFree (w_slotFree),
        .o_nextY    (w_nextY),
        .o_nextCnt  (w_nextCnt),
        .o_push     (w_stepPush)
    );

    // Scan pointer: advance and wrap while enabled, recover from unused codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (!w_ptrValid) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
        end
    end

    // Threshold is sampled only at scan wrap so one scan always uses one value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thrQ <= CNT_W'(THR_DEFAULT);
        end else if (w_wrap) begin
            r_thrQ <= (thr == '0) ? CNT_W'(1) : thr;
        end
    end

    // Per-channel level and run counter, updated for the visited channel only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_visit) begin
            r_y[r_ptr]   <= w_nextY;
            r_cnt[r_ptr] <= w_nextCnt;
        end
    end

`ifdef FILT_SCHED_EVT_FIFO_EN
    logic [FIFO_AW-1:0] r_rd;
    logic [FIFO_AW-1:0] r_wr;
    logic [FIFO_CW-1:0] r_count;
    evt_t               r_mem [FIFO_DEPTH];

    assign w_slotFree  = (r_count != FIFO_CW'(FIFO_DEPTH)) || w_pop;
    assign w_headValid = (r_count != '0);
    assign w_head      = r_mem[r_rd];

    // Event FIFO: oldest entry at the head, push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_newEvt;
                r_wr        <= (r_wr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    evt_t r_evt;
    logic r_evtValid;

    assign w_slotFree  = !r_evtValid || evt_ready;
    assign w_headValid = r_evtValid;
    assign w_head      = r_evt;

    // Single event register: a new event may replace one leaving this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt      <= '0;
            r_evtValid <= 1'b0;
        end else if (w_push) begin
            r_evt      <= w_newEvt;
            r_evtValid <= 1'b1;
        end else if (w_pop) begin
            r_evtValid <= 1'b0;
        end
    end
`endif

    assign w_unusedChBits = |w_head.ch;
    assign y              = r_y;
    assign evt_valid      = w_headValid;
    assign evt_ch         = w_head.ch[CH_W-1:0];
    assign evt_val        = w_head.val;

endmodule
